jtag_tap_os: RTL and testbench
==============================

JTAG_TAP_OS -- requirements
Module: jtag_tap_os

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 4, instruction register width.
REQ-002 SHALL have parameter IDCODE_VALUE, default 32'h149511C3, IDCODE DR content.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, pad synchronizer depth (2..4).
REQ-004 SHALL use one clock and an asynchronous active-low reset: sys_clock, sys_reset_n.
REQ-005 Ports (name direction width meaning):
- sys_clock in 1 system clock
- sys_reset_n in 1 async active-low reset
- tck_pad_i in 1 JTAG TCK from the VPI driver (asynchronous)
- tms_pad_i in 1 JTAG TMS
- tdi_pad_i in 1 JTAG TDI
- tdo_pad_o out 1 JTAG TDO
- tdo_oe_o out 1 TDO valid (Shift-IR/Shift-DR)
- tck_rise_o out 1 one-cycle strobe per detected TCK rising edge
- tdi_o out 1 synchronized TDI
- capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o out 1 each, level while TAP is in that state
- debug_select_o out 1 IR holds DEBUG
- debug_tdo_i in 1 serial data from debug unit

Function
REQ-006 SHALL pass tck/tms/tdi through SYNC_STAGES flops; rise = synced tck 0->1, fall = 1->0, each a one-cycle event.
REQ-007 SHALL act only on rise/fall events; TCK high and low phases each need >= SYNC_STAGES+1 sys_clock cycles; shorter phases are unsupported.
REQ-008 SHALL implement the 16-state IEEE 1149.1 TAP FSM, advancing only on rise, using TMS sampled in that cycle.
REQ-009 SHALL reach Test-Logic-Reset after 5 consecutive rises with TMS=1 from any state.
REQ-010 Instructions: EXTEST 0x0, SAMPLE 0x1, IDCODE 0x2, DEBUG 0x8, BYPASS 0xF; any other code SHALL behave as BYPASS.
REQ-011 Capture-IR SHALL load shift-IR with 'b0101 (LSBs 01); Shift-IR shifts LSB-first, TDI into MSB; Update-IR copies to IR.
REQ-012 Test-Logic-Reset SHALL force IR to IDCODE (BYPASS if macro absent).
REQ-013 DR select: IDCODE -> 32-bit ID register (Capture-DR loads IDCODE_VALUE); BYPASS/EXTEST/SAMPLE -> 1-bit bypass (captures 0); DEBUG -> debug_tdo_i.
REQ-014 On fall, tdo_pad_o SHALL update from shift-IR LSB in Shift-IR, selected DR LSB in Shift-DR, else hold; tdo_oe_o SHALL equal (state is Shift-IR or Shift-DR), updated on fall.
REQ-015 Rise with state transition and shift SHALL occur in the same cycle; state-level outputs change the cycle after the rise.
REQ-016 Simultaneous rise and fall cannot occur; a fall while FSM in Test-Logic-Reset SHALL drive tdo_pad_o=0.

Reset
REQ-017 On sys_reset_n low: synchronizers 0, FSM Test-Logic-Reset, IR=IDCODE (BYPASS if macro absent), shift registers 0, all outputs 0.
REQ-018 Reset mid-shift SHALL abort immediately; after release the first rise is processed normally.

Configuration
REQ-019 Macro JTAG_TAP_IDCODE_EN: defined -> IDCODE register and instruction present; undefined -> no ID register, code 0x2 treated as BYPASS, reset IR = BYPASS.

Structure
REQ-020 Package jtag_tap_pkg SHALL hold the TAP state enum and instruction code constants.
REQ-021 Sub-module jtag_tap_sync (synchronizer + edge detector) SHALL be instantiated once for the pad signals.

Verification
REQ-022 Reset, no TCK -> tdo_oe_o=0, debug_select_o=0, all state levels 0.
REQ-023 After reset, TMS 0,1,0,0 then 32 Shift-DR rises -> TDO bits LSB-first = 0x149511C3.
REQ-024 Shift IR 0x8, Update-IR -> debug_select_o=1; Shift-DR with debug_tdo_i=1 -> tdo_pad_o=1 after next fall.
REQ-025 IR=0xF, shift TDI 1,0,1,1 -> TDO 0,1,0,1 (one-bit delay).
REQ-026 In Shift-DR, 5 rises with TMS=1 -> Test-Logic-Reset, IR=IDCODE, tdo_oe_o=0.
REQ-027 Macro undefined: 32 Shift-DR rises after reset with TDI=1 -> TDO 0 then all 1s (bypass).

Source files
------------

// File: rtl/jtag_tap_pkg.sv
// Shared TAP definitions: state enum, instruction codes, DR select, next-state rule.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a. Build macro JTAG_TAP_IDCODE_EN decides the reset instruction.
package jtag_tap_pkg;

  typedef enum logic [3:0] {
    TAP_TLR    = 4'h0,
    TAP_RTI    = 4'h1,
    TAP_SEL_DR = 4'h2,
    TAP_CAP_DR = 4'h3,
    TAP_SH_DR  = 4'h4,
    TAP_EX1_DR = 4'h5,
    TAP_PA_DR  = 4'h6,
    TAP_EX2_DR = 4'h7,
    TAP_UPD_DR = 4'h8,
    TAP_SEL_IR = 4'h9,
    TAP_CAP_IR = 4'hA,
    TAP_SH_IR  = 4'hB,
    TAP_EX1_IR = 4'hC,
    TAP_PA_IR  = 4'hD,
    TAP_EX2_IR = 4'hE,
    TAP_UPD_IR = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_DEBUG  = 2'd2
  } dr_sel_e;

  localparam logic [3:0] INSTR_EXTEST = 4'h0;
  localparam logic [3:0] INSTR_SAMPLE = 4'h1;
  localparam logic [3:0] INSTR_IDCODE = 4'h2;
  localparam logic [3:0] INSTR_DEBUG  = 4'h8;
  localparam logic [3:0] INSTR_BYPASS = 4'hF;

  // IEEE 1149.1 transition rule for one TCK rising edge.
  function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
    case (s)
      TAP_TLR:    return tms ? TAP_TLR    : TAP_RTI;
      TAP_RTI:    return tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_DR: return tms ? TAP_SEL_IR : TAP_CAP_DR;
      TAP_CAP_DR: return tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_SH_DR:  return tms ? TAP_EX1_DR : TAP_SH_DR;
      TAP_EX1_DR: return tms ? TAP_UPD_DR : TAP_PA_DR;
      TAP_PA_DR:  return tms ? TAP_EX2_DR : TAP_PA_DR;
      TAP_EX2_DR: return tms ? TAP_UPD_DR : TAP_SH_DR;
      TAP_UPD_DR: return tms ? TAP_SEL_DR : TAP_RTI;
      TAP_SEL_IR: return tms ? TAP_TLR    : TAP_CAP_IR;
      TAP_CAP_IR: return tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_SH_IR:  return tms ? TAP_EX1_IR : TAP_SH_IR;
      TAP_EX1_IR: return tms ? TAP_UPD_IR : TAP_PA_IR;
      TAP_PA_IR:  return tms ? TAP_EX2_IR : TAP_PA_IR;
      TAP_EX2_IR: return tms ? TAP_UPD_IR : TAP_SH_IR;
      TAP_UPD_IR: return tms ? TAP_SEL_DR : TAP_RTI;
      default:    return TAP_TLR;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_os_if.sv
// Synchronized pad view: TCK edge strobes plus TMS/TDI aligned to them.
// Latency: carries whatever the synchronizer produces, no extra stage.
// Backpressure: none, events are single-cycle strobes.
interface jtag_tap_os_if;
  logic tck_rise;
  logic tck_fall;
  logic tms;
  logic tdi;

  modport master (output tck_rise, output tck_fall, output tms, output tdi);
  modport slave  (input  tck_rise, input  tck_fall, input  tms, input  tdi);
endinterface

// File: rtl/jtag_tap_sync.sv
// Pad synchronizer for TCK/TMS/TDI plus TCK rise/fall edge detection.
// Latency: SYNC_STAGES sys_clock cycles from pad change to strobe.
// Backpressure: none; TCK phases shorter than SYNC_STAGES+1 cycles are unsupported.
module jtag_tap_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic          sys_clock,
  input  logic          sys_reset_n,
  input  logic          tck_pad_i,
  input  logic          tms_pad_i,
  input  logic          tdi_pad_i,
  jtag_tap_os_if.master sync_if
);

  logic [SYNC_STAGES-1:0] r_tck_sh;
  logic [SYNC_STAGES-1:0] r_tms_sh;
  logic [SYNC_STAGES-1:0] r_tdi_sh;
  logic                   r_tck_prev;

  // Shift all three pads through the same depth so TMS/TDI stay aligned to TCK.
  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_tck_sh   <= '0;
      r_tms_sh   <= '0;
      r_tdi_sh   <= '0;
      r_tck_prev <= 1'b0;
    end else begin
      r_tck_sh   <= {r_tck_sh[SYNC_STAGES-2:0], tck_pad_i};
      r_tms_sh   <= {r_tms_sh[SYNC_STAGES-2:0], tms_pad_i};
      r_tdi_sh   <= {r_tdi_sh[SYNC_STAGES-2:0], tdi_pad_i};
      r_tck_prev <= r_tck_sh[SYNC_STAGES-1];
    end
  end

  assign sync_if.tck_rise = r_tck_sh[SYNC_STAGES-1] & ~r_tck_prev;
  assign sync_if.tck_fall = ~r_tck_sh[SYNC_STAGES-1] & r_tck_prev;
  assign sync_if.tms      = r_tms_sh[SYNC_STAGES-1];
  assign sync_if.tdi      = r_tdi_sh[SYNC_STAGES-1];

endmodule

// File: rtl/jtag_tap_os.sv
// Oversampled JTAG TAP: FSM, IR, bypass/IDCODE/debug DR select, TDO driven on TCK fall.
// Latency: state/shift on the cycle of a detected rise; levels visible the next cycle.
// Backpressure: none. Macro JTAG_TAP_IDCODE_EN adds the IDCODE register and instruction.
module jtag_tap_os
  import jtag_tap_pkg::*;
#(
  parameter int          IR_WIDTH     = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h149511C3,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic sys_clock,
  input  logic sys_reset_n,
  input  logic tck_pad_i,
  input  logic tms_pad_i,
  input  logic tdi_pad_i,
  output logic tdo_pad_o,
  output logic tdo_oe_o,
  output logic tck_rise_o,
  output logic tdi_o,
  output logic capture_dr_o,
  output logic shift_dr_o,
  output logic pause_dr_o,
  output logic update_dr_o,
  output logic debug_select_o,
  input  logic debug_tdo_i
);

  // Capture-IR pattern: LSBs 01 so a broken scan chain is visible at the host.
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(4'b0101);
`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_RESET = IR_WIDTH'(INSTR_IDCODE);
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET = IR_WIDTH'(INSTR_BYPASS);
`endif

  jtag_tap_os_if w_pad_if ();

  jtag_tap_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .sys_clock   (sys_clock),
    .sys_reset_n (sys_reset_n),
    .tck_pad_i   (tck_pad_i),
    .tms_pad_i   (tms_pad_i),
    .tdi_pad_i   (tdi_pad_i),
    .sync_if     (w_pad_if)
  );

  tap_state_e          r_state;
  logic [IR_WIDTH-1:0] r_ir;
  logic [IR_WIDTH-1:0] r_ir_sh;
  logic                r_bypass;
  logic                r_tdo;
  logic                r_tdo_oe;
  dr_sel_e             w_dr_sel;
  logic                w_dr_lsb;
`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0]         r_id_sh;
`else
  logic                w_unused_idcode;
  assign w_unused_idcode = ^IDCODE_VALUE;
`endif

  // TAP state advances only on a detected TCK rise, using the aligned TMS.
  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_state <= TAP_TLR;
    end else if (w_pad_if.tck_rise) begin
      r_state <= tap_next(r_state, w_pad_if.tms);
    end
  end

  // Instruction path: capture/shift on rise, update on fall, forced while in Test-Logic-Reset.
  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_ir    <= IR_RESET;
      r_ir_sh <= '0;
    end else begin
      if (r_state == TAP_TLR) begin
        r_ir <= IR_RESET;
      end else if (w_pad_if.tck_fall && (r_state == TAP_UPD_IR)) begin
        r_ir <= r_ir_sh;
      end
      if (w_pad_if.tck_rise) begin
        case (r_state)
          TAP_CAP_IR: r_ir_sh <= IR_CAPTURE;
          TAP_SH_IR:  r_ir_sh <= {w_pad_if.tdi, r_ir_sh[IR_WIDTH-1:1]};
          default:    ;
        endcase
      end
    end
  end

  // Decode the IR into a DR selection; unknown codes fall back to bypass.
  always_comb begin
    w_dr_sel = DR_BYPASS;
    case (r_ir)
      IR_WIDTH'(INSTR_EXTEST),
      IR_WIDTH'(INSTR_SAMPLE),
      IR_WIDTH'(INSTR_BYPASS): w_dr_sel = DR_BYPASS;
      IR_WIDTH'(INSTR_DEBUG):  w_dr_sel = DR_DEBUG;
`ifdef JTAG_TAP_IDCODE_EN
      IR_WIDTH'(INSTR_IDCODE): w_dr_sel = DR_IDCODE;
`else
      IR_WIDTH'(INSTR_IDCODE): w_dr_sel = DR_BYPASS;
`endif
      default:                 w_dr_sel = DR_BYPASS;
    endcase
  end

  // Bypass bit: captures 0, then a one-bit delay line while selected.
  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_bypass <= 1'b0;
    end else if (w_pad_if.tck_rise) begin
      if (r_state == TAP_CAP_DR) begin
        r_bypass <= 1'b0;
      end else if ((r_state == TAP_SH_DR) && (w_dr_sel == DR_BYPASS)) begin
        r_bypass <= w_pad_if.tdi;
      end
    end
  end

`ifdef JTAG_TAP_IDCODE_EN
  // ID register: loads the device ID on capture, shifts LSB-first while selected.
  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_id_sh <= '0;
    end else if (w_pad_if.tck_rise) begin
      if (r_state == TAP_CAP_DR) begin
        r_id_sh <= IDCODE_VALUE;
      end else if ((r_state == TAP_SH_DR) && (w_dr_sel == DR_IDCODE)) begin
        r_id_sh <= {w_pad_if.tdi, r_id_sh[31:1]};
      end
    end
  end
`endif

  // Serial bit the selected DR presents to TDO.
  always_comb begin
    w_dr_lsb = r_bypass;
    case (w_dr_sel)
      DR_DEBUG:  w_dr_lsb = debug_tdo_i;
`ifdef JTAG_TAP_IDCODE_EN
      DR_IDCODE: w_dr_lsb = r_id_sh[0];
`endif
      default:   w_dr_lsb = r_bypass;
    endcase
  end

  // TDO and its enable change only on TCK fall, so the host samples a stable bit on rise.
  always_ff @(posedge sys_clock or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      r_tdo    <= 1'b0;
      r_tdo_oe <= 1'b0;
    end else if (w_pad_if.tck_fall) begin
      r_tdo_oe <= (r_state == TAP_SH_IR) || (r_state == TAP_SH_DR);
      case (r_state)
        TAP_SH_IR: r_tdo <= r_ir_sh[0];
        TAP_SH_DR: r_tdo <= w_dr_lsb;
        TAP_TLR:   r_tdo <= 1'b0;
        default:   ;
      endcase
    end
  end

  assign tdo_pad_o      = r_tdo;
  assign tdo_oe_o       = r_tdo_oe;
  assign tck_rise_o     = w_pad_if.tck_rise;
  assign tdi_o          = w_pad_if.tdi;
  assign capture_dr_o   = (r_state == TAP_CAP_DR);
  assign shift_dr_o     = (r_state == TAP_SH_DR);
  assign pause_dr_o     = (r_state == TAP_PA_DR);
  assign update_dr_o    = (r_state == TAP_UPD_DR);
  assign debug_select_o = (w_dr_sel == DR_DEBUG);

endmodule

// File: tb/tb_jtag_tap_os.sv
// Bench for jtag_tap_os: TCK driven as slow oversampled pad, results vs. a rule-level model.
// Latency: n/a. Backpressure: n/a.
// Honours JTAG_TAP_IDCODE_EN the same way as the design build.
module tb_jtag_tap_os;

  localparam logic [31:0] IDV = 32'h149511C3;
`ifdef JTAG_TAP_IDCODE_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif
  localparam logic [3:0] RESET_IR = ID_EN ? 4'h2 : 4'hF;

  logic sys_clock = 1'b0;
  logic sys_reset_n = 1'b0;
  logic tck_pad_i = 1'b0, tms_pad_i = 1'b0, tdi_pad_i = 1'b0;
  logic tdo_pad_o, tdo_oe_o, tck_rise_o, tdi_o;
  logic capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o;
  logic debug_select_o;
  logic debug_tdo_i = 1'b0;

  jtag_tap_os #(
    .IR_WIDTH     (4),
    .IDCODE_VALUE (IDV),
    .SYNC_STAGES  (2)
  ) dut (
    .sys_clock      (sys_clock),
    .sys_reset_n    (sys_reset_n),
    .tck_pad_i      (tck_pad_i),
    .tms_pad_i      (tms_pad_i),
    .tdi_pad_i      (tdi_pad_i),
    .tdo_pad_o      (tdo_pad_o),
    .tdo_oe_o       (tdo_oe_o),
    .tck_rise_o     (tck_rise_o),
    .tdi_o          (tdi_o),
    .capture_dr_o   (capture_dr_o),
    .shift_dr_o     (shift_dr_o),
    .pause_dr_o     (pause_dr_o),
    .update_dr_o    (update_dr_o),
    .debug_select_o (debug_select_o),
    .debug_tdo_i    (debug_tdo_i)
  );

  always #5 sys_clock = ~sys_clock;

  int errors = 0;
  int checks = 0;
  int rise_cnt = 0;
  int tck_cnt = 0;
  logic [3:0] model_ir;

  always @(negedge sys_clock) if (tck_rise_o === 1'b1) rise_cnt++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: bench did not reach its summary in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge sys_clock);
    #1;
  endtask

  // One full TCK period: set TMS/TDI while low, raise, lower; return after the fall settles.
  task automatic tck_cycle(input logic tms, input logic tdi);
    tms_pad_i = tms;
    tdi_pad_i = tdi;
    wait_cyc(int'($urandom_range(7, 4)));
    tck_pad_i = 1'b1;
    wait_cyc(int'($urandom_range(7, 4)));
    tck_pad_i = 1'b0;
    wait_cyc(int'($urandom_range(7, 4)));
    tck_cnt++;
  endtask

  // Expected 32 TDO bits of a DR scan from the instruction rules alone.
  function automatic logic [31:0] expect_dr(input logic [3:0] ir, input logic [31:0] din,
                                            input logic dbg);
    if (ir == 4'h8) return {32{dbg}};
    if ((ir == 4'h2) && ID_EN) return IDV;
    return {din[30:0], 1'b0};
  endfunction

  // From Run-Test/Idle: scan a new IR value, return the captured bits; ends in Run-Test/Idle.
  task automatic shift_ir(input logic [3:0] code, output logic [3:0] cap);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    check("oe_in_shift_ir", 32'(tdo_oe_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      cap[i] = tdo_pad_o;
      tck_cycle(i == 3, code[i]);
    end
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    model_ir = code;
  endtask

  // From Run-Test/Idle: 32-bit DR scan; ends in Run-Test/Idle.
  task automatic shift_dr(input logic [31:0] din, output logic [31:0] dout);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    check("capture_dr_level", 32'(capture_dr_o), 32'd1);
    tck_cycle(1'b0, 1'b0);
    check("shift_dr_level_oe", 32'({shift_dr_o, tdo_oe_o}), 32'd3);
    for (int i = 0; i < 32; i++) begin
      dout[i] = tdo_pad_o;
      tck_cycle(i == 31, din[i]);
    end
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
  endtask

  initial begin
    logic [31:0] din, dout;
    logic [3:0]  cap, code;
    logic        dbg;

    // Reset with no TCK activity.
    model_ir = RESET_IR;
    wait_cyc(3);
    check("reset_outputs", 32'({tdo_oe_o, debug_select_o, tdo_pad_o, tck_rise_o, tdi_o}), 32'd0);
    check("reset_levels", 32'({capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o}), 32'd0);
    sys_reset_n = 1'b1;
    wait_cyc(4);
    check("idle_levels", 32'({capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o, tdo_oe_o}), 32'd0);

    // First DR scan after reset: ID register or bypass depending on build.
    tck_cycle(1'b0, 1'b0);
    din = $urandom();
    shift_dr(din, dout);
    check("dr_after_reset", dout, expect_dr(model_ir, din, 1'b0));
    shift_dr(32'hFFFF_FFFF, dout);
    check("dr_reset_ones", dout, expect_dr(model_ir, 32'hFFFF_FFFF, 1'b0));

    // BYPASS: capture pattern and one-bit delay.
    shift_ir(4'hF, cap);
    check("ir_capture", 32'(cap), 32'h5);
    din = {$urandom() & 32'hFFFF_FFF0} | 32'hD;
    shift_dr(din, dout);
    check("bypass_1011", 32'(dout[3:0]), 32'hA);
    check("bypass_scan", dout, expect_dr(model_ir, din, 1'b0));

    // DEBUG: selection flag and TDO from the debug unit.
    shift_ir(4'h8, cap);
    check("debug_select", 32'(debug_select_o), 32'd1);
    debug_tdo_i = 1'b1;
    din = $urandom();
    shift_dr(din, dout);
    check("debug_tdo", dout, expect_dr(model_ir, din, 1'b1));

    // Random instructions and data.
    for (int k = 0; k < 6; k++) begin
      code = 4'($urandom_range(15, 0));
      dbg  = 1'($urandom());
      shift_ir(code, cap);
      check("rand_ir_capture", 32'(cap), 32'h5);
      check("rand_debug_select", 32'(debug_select_o), 32'(code == 4'h8));
      debug_tdo_i = dbg;
      din = $urandom();
      shift_dr(din, dout);
      check("rand_dr_scan", dout, expect_dr(model_ir, din, dbg));
    end

    // Walk through Pause-DR and Update-DR.
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    check("pause_dr_level", 32'({pause_dr_o, tdo_oe_o}), 32'h2);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b1, 1'b0);
    check("update_dr_level", 32'(update_dr_o), 32'd1);
    tck_cycle(1'b0, 1'b0);
    check("rti_levels", 32'({capture_dr_o, shift_dr_o, pause_dr_o, update_dr_o}), 32'd0);

    // Five TMS=1 rises from Shift-DR reach Test-Logic-Reset and restore the reset IR.
    shift_ir(4'h8, cap);
    debug_tdo_i = 1'b1;
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    check("debug_tdo_first", 32'({tdo_pad_o, tdo_oe_o}), 32'h3);
    for (int i = 0; i < 5; i++) tck_cycle(1'b1, 1'b0);
    model_ir = RESET_IR;
    check("tlr_outputs", 32'({tdo_oe_o, tdo_pad_o, debug_select_o, shift_dr_o}), 32'd0);
    tck_cycle(1'b0, 1'b0);
    din = $urandom();
    shift_dr(din, dout);
    check("dr_after_tlr", dout, expect_dr(model_ir, din, 1'b1));

    // Reset in the middle of a debug Shift-DR.
    shift_ir(4'h8, cap);
    tck_cycle(1'b1, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b0);
    tck_cycle(1'b0, 1'b1);
    sys_reset_n = 1'b0;
    wait_cyc(2);
    check("midshift_reset", 32'({tdo_pad_o, tdo_oe_o, shift_dr_o, debug_select_o}), 32'd0);
    sys_reset_n = 1'b1;
    model_ir = RESET_IR;
    wait_cyc(3);
    tck_cycle(1'b0, 1'b0);
    din = $urandom();
    shift_dr(din, dout);
    check("dr_after_midshift_reset", dout, expect_dr(model_ir, din, 1'b1));

    // Synchronized TDI follows the pad.
    tdi_pad_i = 1'b1;
    wait_cyc(4);
    check("tdi_sync_1", 32'(tdi_o), 32'd1);
    tdi_pad_i = 1'b0;
    wait_cyc(4);
    check("tdi_sync_0", 32'(tdi_o), 32'd0);

    // Exactly one strobe per TCK period driven.
    check("rise_strobes", 32'(rise_cnt), 32'(tck_cnt));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
